// File: rtl/rename_stage_if.sv
// Bundle of the decode/dispatch/ROB/branch-unit signals seen by the rename stage.
// slave  : the rename stage's view
// master : the view of whoever drives it (decode + dispatch + ROB + branch unit)
interface rename_stage_if #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 128
);
    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);

    logic          valid_in;
    logic          ready_in;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          rd_write;
    logic [1:0]    fu_in;
    logic          is_branch;
    logic          valid_out;
    logic          ready_out;
    logic [PW-1:0] ps1;
    logic [PW-1:0] ps2;
    logic [PW-1:0] pd_new;
    logic [PW-1:0] pd_old;
    logic [1:0]    fu_out;
    logic          retire_valid;
    logic [PW-1:0] retire_pd;
    logic          br_resolve;
    logic          mispredict;

    modport slave (
        input  valid_in, rs1, rs2, rd, rd_write, fu_in, is_branch, ready_out,
               retire_valid, retire_pd, br_resolve, mispredict,
        output ready_in, valid_out, ps1, ps2, pd_new, pd_old, fu_out
    );

    modport master (
        output valid_in, rs1, rs2, rd, rd_write, fu_in, is_branch, ready_out,
               retire_valid, retire_pd, br_resolve, mispredict,
        input  ready_in, valid_out, ps1, ps2, pd_new, pd_old, fu_out
    );
endinterface

// File: rtl/rename_stage.sv
// Register rename stage: speculative map table, circular free list and a single
// branch checkpoint (map snapshot + free-list read pointer). One-cycle registered
// output toward dispatch with a valid/ready handshake.
module rename_stage #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 128,
    parameter int FL_DEPTH  = 128
) (
    input  logic          clk,
    input  logic          reset,
    rename_stage_if.slave rn
);
    localparam int PW    = $clog2(PHYS_REGS);
    localparam int FW    = $clog2(FL_DEPTH);
    localparam int PTR_W = FW + 1;
    localparam int NFREE = PHYS_REGS - ARCH_REGS;

    logic [PW-1:0]    map_q      [ARCH_REGS];
    logic [PW-1:0]    map_d      [ARCH_REGS];
    logic [PW-1:0]    ckpt_map_q [ARCH_REGS];
    logic [PW-1:0]    fl_q       [FL_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] ckpt_rd_ptr_q;
    logic             ckpt_valid_q;

    logic             valid_out_q;
    logic [PW-1:0]    ps1_q, ps2_q, pd_new_q, pd_old_q;
    logic [1:0]       fu_out_q;

    logic             alloc, fl_empty, restore, ready, accept, do_retire;
    logic [PW-1:0]    pd_alloc;

    // Extra pointer bit distinguishes empty from full; full cannot occur in use.
    assign alloc     = rn.rd_write && (rn.rd != '0);
    assign fl_empty  = (wr_ptr_q == rd_ptr_q);
    assign restore   = rn.br_resolve && rn.mispredict;
    assign ready     = (!valid_out_q || rn.ready_out) && !(alloc && fl_empty) &&
                       !(rn.is_branch && ckpt_valid_q) && !restore;
    assign accept    = rn.valid_in && ready;
    assign do_retire = rn.retire_valid && (rn.retire_pd != '0);
    assign pd_alloc  = alloc ? fl_q[rd_ptr_q[FW-1:0]] : '0;

    assign rn.ready_in  = ready;
    assign rn.valid_out = valid_out_q;
    assign rn.ps1       = ps1_q;
    assign rn.ps2       = ps2_q;
    assign rn.pd_new    = pd_new_q;
    assign rn.pd_old    = pd_old_q;
    assign rn.fu_out    = fu_out_q;

    // Post-accept map and read pointer; also what a branch checkpoint captures.
    always_comb begin
        map_d    = map_q;
        rd_ptr_d = rd_ptr_q;
        if (accept && alloc) begin
            map_d[rn.rd] = pd_alloc;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        end
    end

    // Speculative map table and free-list head; a mispredict rolls both back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
            rd_ptr_q <= '0;
        end else if (restore) begin
            map_q    <= ckpt_map_q;
            rd_ptr_q <= ckpt_rd_ptr_q;
        end else begin
            map_q    <= map_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Single branch checkpoint; a second branch is held off by ready until resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) ckpt_map_q[i] <= PW'(i);
            ckpt_rd_ptr_q <= '0;
            ckpt_valid_q  <= 1'b0;
        end else if (accept && rn.is_branch) begin
            ckpt_map_q    <= map_d;
            ckpt_rd_ptr_q <= rd_ptr_d;
            ckpt_valid_q  <= 1'b1;
        end else if (rn.br_resolve) begin
            ckpt_valid_q  <= 1'b0;
        end
    end

    // Free-list storage and tail; retires land every cycle, mispredict or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++)
                fl_q[i] <= (i < NFREE) ? PW'(i + ARCH_REGS) : '0;
            wr_ptr_q <= PTR_W'(NFREE);
        end else if (do_retire) begin
            fl_q[wr_ptr_q[FW-1:0]] <= rn.retire_pd;
            wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
        end
    end

    // Output register: load on accept, drop when consumed, killed by mispredict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            ps1_q       <= '0;
            ps2_q       <= '0;
            pd_new_q    <= '0;
            pd_old_q    <= '0;
            fu_out_q    <= '0;
        end else if (restore) begin
            valid_out_q <= 1'b0;
        end else if (accept) begin
            valid_out_q <= 1'b1;
            ps1_q       <= map_q[rn.rs1];
            ps2_q       <= map_q[rn.rs2];
            pd_new_q    <= pd_alloc;
            pd_old_q    <= map_q[rn.rd];
            fu_out_q    <= rn.fu_in;
        end else if (rn.ready_out) begin
            valid_out_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: a queue/array reference model predicts ready_in and the
// renamed output of every accepted instruction; a monitor pops and compares.
module tb_rename_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rename_stage_if bus ();
    rename_stage dut (.clk(clk), .reset(reset), .rn(bus));

    typedef struct {int ps1; int ps2; int pdn; int pdo; int fu;} exp_t;

    int   m_map[32];
    int   m_ckpt_map[32];
    int   m_free[$];
    int   m_since[$];
    int   pool[$];
    bit   m_ckpt;
    bit   m_vout;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   last_ready;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_map[i] = i;
            m_ckpt_map[i] = i;
        end
        m_free.delete();
        for (int p = 32; p < 128; p++) m_free.push_back(p);
        m_since.delete();
        pool.delete();
        sb.delete();
        m_ckpt = 1'b0;
        m_vout = 1'b0;
    endtask

    task automatic drive_idle();
        bus.valid_in = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.rd_write = 0;
        bus.fu_in = 0; bus.is_branch = 0; bus.ready_out = 1; bus.retire_valid = 0;
        bus.retire_pd = 0; bus.br_resolve = 0; bus.mispredict = 0;
    endtask

    // One clock of stimulus; the model advances just before the rising edge.
    task automatic cycle(input bit v, input int r1, input int r2, input int rdd, input bit rw,
                         input int fu, input bit br, input bit ro, input bit rv, input int rpd,
                         input bit bres, input bit mis);
        bit alloc, rdy, acc, rst;
        exp_t e;
        @(negedge clk);
        bus.valid_in = v; bus.rs1 = 5'(r1); bus.rs2 = 5'(r2); bus.rd = 5'(rdd);
        bus.rd_write = rw; bus.fu_in = 2'(fu); bus.is_branch = br; bus.ready_out = ro;
        bus.retire_valid = rv; bus.retire_pd = 7'(rpd); bus.br_resolve = bres;
        bus.mispredict = mis;
        alloc = rw && (rdd != 0);
        rst   = bres && mis;
        rdy   = (!m_vout || ro) && !(alloc && m_free.size() == 0) && !(br && m_ckpt) && !rst;
        #1;
        chk("ready_in", bus.ready_in, rdy);
        last_ready = bus.ready_in;
        acc = v && rdy;
        #3;
        if (rv && rpd != 0) m_free.push_back(rpd);
        if (rst) begin
            m_map = m_ckpt_map;
            for (int i = m_since.size() - 1; i >= 0; i--) m_free.push_front(m_since[i]);
            m_since.delete();
            m_ckpt = 1'b0;
            m_vout = 1'b0;
        end else begin
            if (bres) begin
                m_ckpt = 1'b0;
                m_since.delete();
            end
            if (acc) begin
                e.ps1 = m_map[r1]; e.ps2 = m_map[r2]; e.pdo = m_map[rdd];
                e.fu = fu; e.pdn = 0;
                if (alloc) begin
                    e.pdn = m_free.pop_front();
                    m_map[rdd] = e.pdn;
                    if (m_ckpt) m_since.push_back(e.pdn);
                    pool.push_back(e.pdo);
                end
                if (br) begin
                    m_ckpt_map = m_map;
                    m_ckpt = 1'b1;
                    m_since.delete();
                end
                sb.push_back(e);
                m_vout = 1'b1;
            end else if (ro) begin
                m_vout = 1'b0;
            end
        end
    endtask

    task automatic ins(input int r1, input int r2, input int rdd, input bit rw, input bit br);
        cycle(1, r1, r2, rdd, rw, 1, br, 1, 0, 0, 0, 0);
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        drive_idle();
        reset = 1'b1;
        #2;
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_ps1", bus.ps1, 0);
        chk("rst_ps2", bus.ps2, 0);
        chk("rst_pd_new", bus.pd_new, 0);
        chk("rst_pd_old", bus.pd_old, 0);
        chk("rst_fu_out", bus.fu_out, 0);
        chk("rst_ready_in", bus.ready_in, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        mon_en = 1'b1;
    endtask

    // Monitor: any presented output must match the oldest expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("valid_out", bus.valid_out, (sb.size() != 0) ? 1 : 0);
                if (bus.valid_out === 1'b1 && sb.size() != 0) begin
                    e = sb[0];
                    checks++;
                    if (bus.ps1 !== 7'(e.ps1) || bus.ps2 !== 7'(e.ps2) || bus.pd_new !== 7'(e.pdn) ||
                        bus.pd_old !== 7'(e.pdo) || bus.fu_out !== 2'(e.fu)) begin
                        errors++;
                        $display("FAIL out: got ps1=%0d ps2=%0d pdn=%0d pdo=%0d fu=%0d expected ps1=%0d ps2=%0d pdn=%0d pdo=%0d fu=%0d at %0t",
                                 bus.ps1, bus.ps2, bus.pd_new, bus.pd_old, bus.fu_out,
                                 e.ps1, e.ps2, e.pdn, e.pdo, e.fu, $time);
                    end
                    if (bus.ready_out || (bus.br_resolve && bus.mispredict)) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bit v, rw, br, ro, rv, bres, mis;
        int r1, r2, rdd, fu, rpd;

        // Basic rename and read-before-update
        do_reset();
        ins(5, 0, 5, 1, 0); post();
        chk("first_ps1", bus.ps1, 5); chk("first_pd_old", bus.pd_old, 5);
        chk("first_pd_new", bus.pd_new, 32);
        ins(5, 5, 6, 1, 0); post();
        chk("second_ps1", bus.ps1, 32); chk("second_pd_new", bus.pd_new, 33);
        ins(1, 2, 0, 1, 0); post();
        chk("rd0_pd_new", bus.pd_new, 0);
        ins(7, 0, 7, 0, 0); post();
        chk("nowrite_pd_new", bus.pd_new, 0); chk("nowrite_pd_old", bus.pd_old, 7);
        ins(7, 0, 7, 1, 0); post();
        chk("after_noalloc_pd_new", bus.pd_new, 34); chk("map_unchanged", bus.pd_old, 7);

        // Free-list exhaustion and refill by retire
        do_reset();
        for (int i = 0; i < 96; i++) ins(i % 32, (i + 3) % 32, (i % 31) + 1, 1, 0);
        post();
        chk("last_alloc", bus.pd_new, 127);
        ins(0, 0, 3, 1, 0);
        chk("empty_stall", last_ready, 0);
        cycle(1, 0, 0, 3, 1, 1, 0, 1, 1, 40, 0, 0);
        chk("retire_same_cycle", last_ready, 0);
        ins(0, 0, 3, 1, 0);
        chk("retire_next_cycle", last_ready, 1);
        post();
        chk("refill_pd_new", bus.pd_new, 40);

        // Checkpoint and mispredict rollback
        do_reset();
        ins(0, 0, 1, 1, 0); ins(0, 0, 2, 1, 0); ins(0, 0, 3, 1, 0);
        ins(0, 0, 9, 0, 1);
        ins(0, 0, 1, 1, 0); ins(0, 0, 4, 1, 0);
        cycle(1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 1, 1);
        chk("mispredict_no_accept", last_ready, 0);
        post();
        chk("mispredict_kill", bus.valid_out, 0);
        ins(1, 4, 1, 1, 0); post();
        chk("restored_ps1", bus.ps1, 32); chk("restored_ps2", bus.ps2, 4);
        chk("restored_pd_new", bus.pd_new, 35);

        // Back-pressure hold and second-branch stall
        do_reset();
        cycle(1, 1, 2, 2, 1, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 3, 1, 2, 1, 0, 0, 0, 0, 0);
            chk("stall_ready", last_ready, 0);
            post();
            chk("stall_hold", bus.pd_new, 32);
        end
        cycle(1, 0, 0, 3, 1, 2, 1, 1, 0, 0, 0, 0);
        chk("second_branch_stall", last_ready, 0);
        cycle(1, 0, 0, 3, 1, 2, 1, 1, 0, 0, 1, 0);
        chk("resolve_cycle_stall", last_ready, 0);
        cycle(1, 0, 0, 3, 1, 2, 1, 1, 0, 0, 0, 0);
        chk("branch_after_resolve", last_ready, 1);

        // Asynchronous reset with pending output and live checkpoint
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        post();
        chk("pre_reset_valid", bus.valid_out, 1);
        do_reset();
        ins(0, 0, 5, 1, 0); post();
        chk("post_reset_pd_new", bus.pd_new, 32);
        ins(0, 0, 0, 0, 1);
        chk("post_reset_branch", last_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom % 4) != 0;
            r1 = $urandom % 32; r2 = $urandom % 32; rdd = $urandom % 32;
            rw = ($urandom % 4) != 0;
            fu = 1 + ($urandom % 3);
            br = ($urandom % 6) == 0;
            ro = ($urandom % 4) != 0;
            rv = 0; rpd = 0;
            if (($urandom % 3) == 0) begin
                rv = 1;
                if (pool.size() > 0 && m_free.size() + m_since.size() < 120) rpd = pool.pop_front();
            end
            bres = 0; mis = 0;
            if (m_ckpt && ($urandom % 5) == 0) begin
                bres = 1;
                mis = $urandom % 2;
            end
            cycle(v, r1, r2, rdd, rw, fu, br, ro, rv, rpd, bres, mis);
        end

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        post();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
